// File: rtl/keypad_input_unit_if.sv
// ---------------------------------------------------------------------------
// keypad_input_unit_if
//
// Bundles the keypad matrix pins and the operand/operator outputs of the
// calculator input unit.
//
//   row      keypad rows, active-low (driven by the keypad / outside world)
//   col      column drive, active-low, one-hot-low
//   value    current operand, 16-bit two's complement
//   digits   number of digits accepted into the current operand
//   neg      operand sign flag
//   op       operator code: 00 add, 01 sub, 10 mul, 11 div
//   op_valid one-cycle pulse when an operator key is accepted
//   enter    one-cycle pulse when '#' is accepted
//
// Modports:
//   master - the keypad input unit (samples row, drives everything else)
//   slave  - the surrounding system (drives row, consumes the results)
// ---------------------------------------------------------------------------
interface keypad_input_unit_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] value;
    logic [1:0]  digits;
    logic        neg;
    logic [1:0]  op;
    logic        op_valid;
    logic        enter;

    modport master (
        input  row,
        output col, value, digits, neg, op, op_valid, enter
    );

    modport slave (
        output row,
        input  col, value, digits, neg, op, op_valid, enter
    );
endinterface

// File: rtl/keypad_input_unit.sv
// ---------------------------------------------------------------------------
// keypad_input_unit
//
// Scans a 4x4 active-low matrix keypad, debounces key presses and releases,
// decodes the key, and builds a signed decimal operand for the calculator.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   kp   - keypad_input_unit_if.master: row in; col, value, digits, neg,
//          op, op_valid, enter out
//
// Keymap (row r / column c):
//   r0: 1 2 3 A     A/B/C/D -> op 00/01/10/11
//   r1: 4 5 6 B     '*'     -> toggle sign
//   r2: 7 8 9 C     '#'     -> enter
//   r3: * 0 # D
// ---------------------------------------------------------------------------
module keypad_input_unit #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE   = 4,
    parameter int MAX_DIGITS = 3
) (
    input  logic               clk,
    input  logic               rst,
    keypad_input_unit_if.master kp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE);
    localparam logic [1:0]       DIG_LIMIT  = 2'(MAX_DIGITS);

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    // Scan / debounce state
    state_t           state_q, state_d;
    logic [DIV_W-1:0] dwell_q, dwell_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [3:0]       key_q, key_d;        // {row index, column index}

    // Operand / result state
    logic [7:0]       mag_q, mag_d;
    logic [1:0]       digits_q, digits_d;
    logic             neg_q, neg_d;
    logic [1:0]       op_q, op_d;
    logic             op_valid_q, op_valid_d;
    logic             enter_q, enter_d;

    // Combinational helpers
    logic             tick;
    logic             row_hit;
    logic [1:0]       row_idx;
    logic [3:0]       cur_key;
    logic [DEB_W-1:0] deb_inc;
    logic             accept;
    logic [3:0]       accept_key;

    logic [1:0]       acc_r, acc_c;
    logic             key_is_op, key_is_star, key_is_hash, key_is_digit;
    logic [3:0]       key_digit;
    logic [11:0]      mag_cand;
    logic             digit_ok;

    // -----------------------------------------------------------------------
    // Sampling helpers
    // -----------------------------------------------------------------------
    assign tick    = (dwell_q == DWELL_LAST);
    assign dwell_d = tick ? '0 : dwell_q + 1'b1;
    assign deb_inc = deb_q + 1'b1;
    assign cur_key = {row_idx, col_idx_q};

    // Lowest-index low row wins when several rows are pulled low.
    always_comb begin
        row_hit = 1'b1;
        row_idx = 2'd0;
        casez (kp.row)
            4'b???0: row_idx = 2'd0;
            4'b??01: row_idx = 2'd1;
            4'b?011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_hit = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Scan / debounce FSM: next state. Decisions happen only on sample ticks.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        deb_d      = deb_q;
        key_d      = key_q;
        col_idx_d  = col_idx_q;
        accept     = 1'b0;
        accept_key = key_q;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (row_hit) begin
                        // Column is frozen from here until the release completes.
                        key_d      = cur_key;
                        accept_key = cur_key;
                        if (DEBOUNCE <= 1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            deb_d   = '0;
                        end else begin
                            state_d = DEB_PRESS;
                            deb_d   = DEB_W'(1);
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end

                DEB_PRESS: begin
                    if (row_hit && (cur_key == key_q)) begin
                        if (deb_inc >= DEB_TARGET) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            deb_d   = '0;
                        end else begin
                            deb_d = deb_inc;
                        end
                    end else begin
                        // Bounce or key change: drop back without advancing.
                        state_d = SCAN;
                        deb_d   = '0;
                    end
                end

                HELD: begin
                    if (!row_hit) begin
                        if (DEBOUNCE <= 1) begin
                            state_d   = SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                            deb_d     = '0;
                        end else begin
                            state_d = DEB_REL;
                            deb_d   = DEB_W'(1);
                        end
                    end
                end

                DEB_REL: begin
                    if (row_hit) begin
                        state_d = HELD;
                        deb_d   = '0;
                    end else if (deb_inc >= DEB_TARGET) begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                        deb_d     = '0;
                    end else begin
                        deb_d = deb_inc;
                    end
                end

                default: begin
                    state_d = SCAN;
                    deb_d   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Key decode of the key being accepted
    // -----------------------------------------------------------------------
    assign acc_r = accept_key[3:2];
    assign acc_c = accept_key[1:0];

    always_comb begin
        key_is_op    = (acc_c == 2'd3);
        key_is_star  = (acc_r == 2'd3) && (acc_c == 2'd0);
        key_is_hash  = (acc_r == 2'd3) && (acc_c == 2'd2);
        key_is_digit = !key_is_op && !key_is_star && !key_is_hash;
        // Rows 0..2 hold 1..9 laid out row-major; the only digit on row 3 is 0.
        if (acc_r == 2'd3) begin
            key_digit = 4'd0;
        end else begin
            key_digit = ({2'b00, acc_r} * 4'd3) + {2'b00, acc_c} + 4'd1;
        end
    end

    assign mag_cand = ({4'h0, mag_q} * 12'd10) + {8'h00, key_digit};
    assign digit_ok = (digits_q < DIG_LIMIT) && (mag_cand <= 12'd255);

    // -----------------------------------------------------------------------
    // Operand datapath
    // -----------------------------------------------------------------------
    always_comb begin
        mag_d      = mag_q;
        digits_d   = digits_q;
        neg_d      = neg_q;
        op_d       = op_q;
        op_valid_d = 1'b0;
        enter_d    = 1'b0;

        // The operand stays visible during the pulse cycle so the consumer
        // can latch it, then clears on the following edge.
        if (op_valid_q || enter_q) begin
            mag_d    = 8'h00;
            digits_d = 2'd0;
            neg_d    = 1'b0;
        end

        if (accept) begin
            if (key_is_op) begin
                op_d       = acc_r;
                op_valid_d = 1'b1;
            end else if (key_is_star) begin
                neg_d = ~neg_q;
            end else if (key_is_hash) begin
                enter_d = 1'b1;
            end else if (key_is_digit && digit_ok) begin
                mag_d    = mag_cand[7:0];
                digits_d = digits_q + 2'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCAN;
            dwell_q    <= '0;
            col_idx_q  <= 2'd0;
            deb_q      <= '0;
            key_q      <= 4'd0;
            mag_q      <= 8'h00;
            digits_q   <= 2'd0;
            neg_q      <= 1'b0;
            op_q       <= 2'd0;
            op_valid_q <= 1'b0;
            enter_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            col_idx_q  <= col_idx_d;
            deb_q      <= deb_d;
            key_q      <= key_d;
            mag_q      <= mag_d;
            digits_q   <= digits_d;
            neg_q      <= neg_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            enter_q    <= enter_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign kp.col      = ~(4'b0001 << col_idx_q);
    assign kp.value    = neg_q ? (16'h0000 - {8'h00, mag_q}) : {8'h00, mag_q};
    assign kp.digits   = digits_q;
    assign kp.neg      = neg_q;
    assign kp.op       = op_q;
    assign kp.op_valid = op_valid_q;
    assign kp.enter    = enter_q;

endmodule

// File: tb/tb_keypad_input_unit.sv
// ---------------------------------------------------------------------------
// tb_keypad_input_unit
//
// Directed testbench for keypad_input_unit with SCAN_DIV=4, DEBOUNCE=2,
// MAX_DIGITS=3. A small keypad model pulls the pressed key's row low while
// its column is driven. A negedge monitor counts op_valid/enter pulse cycles
// and captures the operand seen during and right after each pulse.
// ---------------------------------------------------------------------------
module tb_keypad_input_unit;

    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE   = 2;
    localparam int MAX_DIGITS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    keypad_input_unit_if kp_if ();

    keypad_input_unit #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE   (DEBOUNCE),
        .MAX_DIGITS (MAX_DIGITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if)
    );

    always #5 clk = ~clk;

    // Keypad model
    logic       key_down = 1'b0;
    logic [1:0] key_r    = 2'd0;
    logic [1:0] key_c    = 2'd0;

    assign kp_if.row = (key_down && (kp_if.col[key_c] == 1'b0)) ?
                       ~(4'b0001 << key_r) : 4'b1111;

    // Pulse monitor
    int          ov_cnt = 0;
    int          en_cnt = 0;
    logic [1:0]  ov_op     = 2'd0;
    logic [15:0] ov_value  = 16'h0;
    logic [1:0]  ov_digits = 2'd0;
    logic [15:0] en_value  = 16'h0;
    logic [15:0] post_value  = 16'h0;
    logic [1:0]  post_digits = 2'd0;
    logic        pulse_prev  = 1'b0;

    always @(negedge clk) begin
        if (pulse_prev) begin
            post_value  <= kp_if.value;
            post_digits <= kp_if.digits;
        end
        pulse_prev <= kp_if.op_valid | kp_if.enter;
        if (kp_if.op_valid) begin
            ov_cnt    <= ov_cnt + 1;
            ov_op     <= kp_if.op;
            ov_value  <= kp_if.value;
            ov_digits <= kp_if.digits;
        end
        if (kp_if.enter) begin
            en_cnt   <= en_cnt + 1;
            en_value <= kp_if.value;
        end
    end

    int checks = 0;
    int errors = 0;

    // Advance n rising edges and land 2 time units after the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Press a key for hold_cyc cycles, then release and let the release settle.
    task automatic press_key(input logic [1:0] r, input logic [1:0] c, input int hold_cyc);
        key_r    = r;
        key_c    = c;
        key_down = 1'b1;
        cycles(hold_cyc);
        key_down = 1'b0;
        cycles(24);
        $display("key r%0d c%0d: value=%h digits=%0d neg=%0d op_valid_cnt=%0d enter_cnt=%0d",
                 r, c, kp_if.value, kp_if.digits, kp_if.neg, ov_cnt, en_cnt);
    endtask

    task automatic test_reset();
        checks++;
        if ({kp_if.col, kp_if.value, kp_if.digits, kp_if.neg, kp_if.op, kp_if.op_valid, kp_if.enter}
            !== {4'b1110, 16'h0000, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: col=%b value=%h digits=%0d neg=%b op=%b ov=%b en=%b required col=1110 and zeros",
                     kp_if.col, kp_if.value, kp_if.digits, kp_if.neg, kp_if.op, kp_if.op_valid, kp_if.enter);
        end
        // Release reset with '1' (r0,c0) already on the first column.
        @(negedge clk);
        rst      = 1'b0;
        key_r    = 2'd0;
        key_c    = 2'd0;
        key_down = 1'b1;
        // First tick is the 4th edge (-> DEB_PRESS); accept would be the 8th.
        cycles(5);
        rst = 1'b1;
        #1;
        checks++;
        if ({kp_if.col, kp_if.value, kp_if.digits, kp_if.neg, kp_if.op_valid, kp_if.enter}
            !== {4'b1110, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_debounce: col=%b value=%h digits=%0d neg=%b ov=%b en=%b required col=1110 and zeros",
                     kp_if.col, kp_if.value, kp_if.digits, kp_if.neg, kp_if.op_valid, kp_if.enter);
        end
        key_down = 1'b0;
        cycles(2);
        @(negedge clk);
        rst = 1'b0;
        cycles(40);
        checks++;
        if ({kp_if.value, kp_if.digits} !== {16'h0000, 2'd0}) begin
            errors++;
            $display("FAIL reset_no_accept: value=%h digits=%0d required 0000/0", kp_if.value, kp_if.digits);
        end
        checks++;
        if ((ov_cnt + en_cnt) !== 0) begin
            errors++;
            $display("FAIL reset_no_pulse: pulses=%0d required 0", ov_cnt + en_cnt);
        end
        $display("reset test: col=%b value=%h digits=%0d", kp_if.col, kp_if.value, kp_if.digits);
    endtask

    task automatic test_digits();
        int en0;
        en0 = en_cnt;
        press_key(2'd0, 2'd0, 40);   // '1'
        checks++;
        if (kp_if.digits !== 2'd1) begin
            errors++;
            $display("FAIL digits_after_1: got %0d required 1", kp_if.digits);
        end
        press_key(2'd0, 2'd1, 40);   // '2'
        checks++;
        if (kp_if.digits !== 2'd2) begin
            errors++;
            $display("FAIL digits_after_2: got %0d required 2", kp_if.digits);
        end
        press_key(2'd2, 2'd0, 40);   // '7'
        checks++;
        if ({kp_if.value, kp_if.digits, kp_if.neg} !== {16'h007F, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL operand_127: value=%h digits=%0d neg=%b required 007f/3/0",
                     kp_if.value, kp_if.digits, kp_if.neg);
        end
        press_key(2'd3, 2'd2, 40);   // '#'
        checks++;
        if ((en_cnt - en0) !== 1 || en_value !== 16'h007F) begin
            errors++;
            $display("FAIL enter_127: pulses=%0d value=%h required 1/007f", en_cnt - en0, en_value);
        end
        checks++;
        if ({post_value, kp_if.value, kp_if.digits} !== {16'h0000, 16'h0000, 2'd0}) begin
            errors++;
            $display("FAIL clear_after_enter: post=%h value=%h digits=%0d required 0000/0000/0",
                     post_value, kp_if.value, kp_if.digits);
        end
    endtask

    task automatic test_sign();
        press_key(2'd3, 2'd0, 40);   // '*'
        press_key(2'd1, 2'd1, 40);   // '5'
        checks++;
        if ({kp_if.value, kp_if.neg, kp_if.digits} !== {16'hFFFB, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL negative_5: value=%h neg=%b digits=%0d required fffb/1/1",
                     kp_if.value, kp_if.neg, kp_if.digits);
        end
        press_key(2'd3, 2'd0, 40);   // '*'
        checks++;
        if ({kp_if.value, kp_if.neg} !== {16'h0005, 1'b0}) begin
            errors++;
            $display("FAIL sign_toggle_back: value=%h neg=%b required 0005/0", kp_if.value, kp_if.neg);
        end
        press_key(2'd3, 2'd2, 40);   // '#'
    endtask

    task automatic test_limits();
        press_key(2'd0, 2'd1, 40);   // '2'
        press_key(2'd1, 2'd1, 40);   // '5'
        press_key(2'd1, 2'd2, 40);   // '6' -> 256 rejected
        checks++;
        if ({kp_if.value, kp_if.digits} !== {16'h0019, 2'd2}) begin
            errors++;
            $display("FAIL reject_256: value=%h digits=%0d required 0019/2", kp_if.value, kp_if.digits);
        end
        press_key(2'd0, 2'd0, 40);   // '1' -> 251
        checks++;
        if ({kp_if.value, kp_if.digits} !== {16'h00FB, 2'd3}) begin
            errors++;
            $display("FAIL accept_251: value=%h digits=%0d required 00fb/3", kp_if.value, kp_if.digits);
        end
        press_key(2'd0, 2'd2, 40);   // '3' -> digit limit reached
        checks++;
        if ({kp_if.value, kp_if.digits} !== {16'h00FB, 2'd3}) begin
            errors++;
            $display("FAIL max_digits: value=%h digits=%0d required 00fb/3", kp_if.value, kp_if.digits);
        end
        press_key(2'd3, 2'd2, 40);   // '#'
    endtask

    task automatic test_bounce();
        logic [3:0] c0;
        logic       found;
        int         idx;
        int         pulses0;
        pulses0 = ov_cnt + en_cnt;
        c0      = kp_if.col;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #2;
            if (kp_if.col !== c0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL scan_running: col=%b stuck, required a change within 20 cycles", kp_if.col);
        end
        // Just after a column step: the next sample tick is 4 edges away.
        c0  = kp_if.col;
        idx = 0;
        for (int i = 0; i < 4; i++) if (c0[i] == 1'b0) idx = i;
        key_r    = 2'd1;
        key_c    = 2'(idx);
        key_down = 1'b1;
        cycles(4);
        checks++;
        if (kp_if.col !== c0) begin
            errors++;
            $display("FAIL bounce_freeze: col=%b required %b", kp_if.col, c0);
        end
        key_down = 1'b0;
        cycles(4);
        checks++;
        if (kp_if.col !== c0) begin
            errors++;
            $display("FAIL bounce_abort_no_advance: col=%b required %b", kp_if.col, c0);
        end
        cycles(4);
        checks++;
        if (kp_if.col !== {c0[2:0], c0[3]}) begin
            errors++;
            $display("FAIL bounce_scan_resumes: col=%b required %b", kp_if.col, {c0[2:0], c0[3]});
        end
        checks++;
        if ({kp_if.value, kp_if.digits} !== {16'h0000, 2'd0} || (ov_cnt + en_cnt) !== pulses0) begin
            errors++;
            $display("FAIL bounce_no_action: value=%h digits=%0d new_pulses=%0d required 0000/0/0",
                     kp_if.value, kp_if.digits, ov_cnt + en_cnt - pulses0);
        end
        $display("bounce test: col=%b value=%h digits=%0d", kp_if.col, kp_if.value, kp_if.digits);
    endtask

    task automatic test_hold();
        press_key(2'd1, 2'd0, 80);   // '4' held for 20 ticks
        checks++;
        if ({kp_if.value, kp_if.digits} !== {16'h0004, 2'd1}) begin
            errors++;
            $display("FAIL hold_single_accept: value=%h digits=%0d required 0004/1", kp_if.value, kp_if.digits);
        end
        press_key(2'd3, 2'd2, 40);   // '#'
    endtask

    task automatic test_operator();
        int ov0;
        int en0;
        ov0 = ov_cnt;
        press_key(2'd1, 2'd0, 40);   // '4'
        press_key(2'd0, 2'd1, 40);   // '2'
        press_key(2'd1, 2'd3, 40);   // 'B'
        checks++;
        if ((ov_cnt - ov0) !== 1) begin
            errors++;
            $display("FAIL op_valid_width: high cycles=%0d required 1", ov_cnt - ov0);
        end
        checks++;
        if ({ov_op, ov_value, ov_digits} !== {2'b01, 16'h002A, 2'd2}) begin
            errors++;
            $display("FAIL op_capture: op=%b value=%h digits=%0d required 01/002a/2", ov_op, ov_value, ov_digits);
        end
        checks++;
        if ({post_value, post_digits} !== {16'h0000, 2'd0}) begin
            errors++;
            $display("FAIL op_clear_next_cycle: value=%h digits=%0d required 0000/0", post_value, post_digits);
        end
        checks++;
        if (kp_if.op !== 2'b01) begin
            errors++;
            $display("FAIL op_held: op=%b required 01", kp_if.op);
        end
        en0 = en_cnt;
        press_key(2'd3, 2'd2, 40);   // '#'
        checks++;
        if ((en_cnt - en0) !== 1 || en_value !== 16'h0000) begin
            errors++;
            $display("FAIL enter_single_pulse: pulses=%0d value=%h required 1/0000", en_cnt - en0, en_value);
        end
    endtask

    initial begin
        cycles(3);
        test_reset();
        test_digits();
        test_sign();
        test_limits();
        test_bounce();
        test_hold();
        test_operator();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
